// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the MULDIV unit.
package muldiv_pkg;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PREP = 3'd1;
    localparam logic [2:0] ST_ITER = 3'd2;
    localparam logic [2:0] ST_FIX  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;
    localparam logic [31:0] MOST_NEG = 32'h8000_0000;

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division step: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module muldiv_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] rem_shift;
    logic [WIDTH:0] diff;
    logic           fits;

    // Extra top bit keeps the borrow so the compare is exact.
    assign rem_shift = {rem, quo[WIDTH-1]};
    assign diff      = rem_shift - {1'b0, divisor};
    assign fits      = ~diff[WIDTH];
    assign rem_next  = fits ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    assign quo_next  = {quo[WIDTH-2:0], fits};

endmodule

// File: rtl/muldiv_div_seq.sv
// Multi-cycle DIV/DIVU/REM/REMU sequencer: magnitude prep, one restoring
// step per clock, then RISC-V sign and special-case fixup.
//
// state | meaning
// IDLE  | waiting for start
// PREP  | take magnitudes, record signs, detect div-by-zero / overflow
// ITER  | WIDTH restoring-division steps
// FIX   | apply sign rules / special values, register result
// DONE  | one-cycle done pulse, may accept a new start
module muldiv_div_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    logic [2:0]       state;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] divisor;
    logic [CNT_W-1:0] cnt;
    logic             neg_q;
    logic             neg_r;
    logic             special;

    logic             is_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             div_zero;
    logic             overflow;
    logic [WIDTH-1:0] quo_neg;
    logic [WIDTH-1:0] rem_neg;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] fix_value;
    logic             accept;

    assign is_signed = ~op_q[0];
    assign a_neg     = is_signed & a_q[WIDTH-1];
    assign b_neg     = is_signed & b_q[WIDTH-1];
    assign a_mag     = a_neg ? (~a_q + WIDTH'(1)) : a_q;
    assign b_mag     = b_neg ? (~b_q + WIDTH'(1)) : b_q;
    assign div_zero  = (b_q == '0);
    assign overflow  = is_signed && (a_q == MOST_NEG) && (b_q == ALL_ONES);
    assign quo_neg   = ~quo + WIDTH'(1);
    assign rem_neg   = ~rem + WIDTH'(1);
    assign accept    = start && ((state == ST_IDLE) || (state == ST_DONE));

    assign busy = (state == ST_PREP) || (state == ST_ITER) || (state == ST_FIX);
    assign done = (state == ST_DONE);

    muldiv_div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (divisor),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    // op[1] selects remainder over quotient.
    always_comb begin
        fix_value = quo;
        if (special) begin
            if (div_zero)
                fix_value = op_q[1] ? a_q : ALL_ONES;
            else
                fix_value = op_q[1] ? '0 : MOST_NEG;
        end else if (op_q[1]) begin
            fix_value = neg_r ? rem_neg : rem;
        end else begin
            fix_value = neg_q ? quo_neg : quo;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            quo     <= '0;
            rem     <= '0;
            divisor <= '0;
            cnt     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            special <= 1'b0;
            result  <= '0;
        end else begin
            if (accept) begin
                op_q <= op;
                a_q  <= a;
                b_q  <= b;
            end
            case (state)
                ST_IDLE: if (accept) state <= ST_PREP;
                ST_PREP: begin
                    quo     <= a_mag;
                    divisor <= b_mag;
                    rem     <= '0;
                    cnt     <= CNT_W'(WIDTH - 1);
                    neg_q   <= a_neg ^ b_neg;
                    neg_r   <= a_neg;
                    special <= div_zero | overflow;
                    state   <= (div_zero | overflow) ? ST_FIX : ST_ITER;
                end
                ST_ITER: begin
                    rem <= rem_next;
                    quo <= quo_next;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == '0) state <= ST_FIX;
                end
                ST_FIX: begin
                    result <= fix_value;
                    state  <= ST_DONE;
                end
                ST_DONE: state <= accept ? ST_PREP : ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_div_seq.sv
// Scoreboard bench for muldiv_div_seq: directed RISC-V cases, protocol
// corner cases, mid-operation reset, and randomized operands.
module tb_muldiv_div_seq;
    import muldiv_pkg::*;

    typedef struct {
        logic [31:0] res;
        int          due;
    } exp_t;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int   cyc;
    int   compared;
    int   mismatched;
    exp_t exp_q[$];

    muldiv_div_seq #(.WIDTH(32), .CNT_W(5)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    // Reference: RISC-V M-extension divide semantics in plain arithmetic.
    function automatic void ref_div(input logic [1:0] o, input logic [31:0] x,
                                    input logic [31:0] y, output logic [31:0] r,
                                    output int lat);
        bit sgn = (o == OP_DIV) || (o == OP_REM);
        bit ovf = sgn && (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        lat = ((y == 0) || ovf) ? 3 : 35;
        case (o)
            OP_DIV:  r = (y == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000
                       : 32'($signed(x) / $signed(y));
            OP_REM:  r = (y == 0) ? x : ovf ? 32'h0 : 32'($signed(x) % $signed(y));
            OP_DIVU: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
            default: r = (y == 0) ? x : x % y;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pop and compare on every done pulse.
    always @(negedge clk) begin
        if (rstn === 1'b1 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result", result, e.res);
                check("done_cycle", 32'(cyc), 32'(e.due));
                check("busy_in_done", 32'(busy), 32'h0);
            end
        end
    end

    // Called at posedge+1; drives start for one cycle and queues the expectation.
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int st);
        exp_t e;
        int   lat;
        ref_div(o, x, y, e.res, lat);
        st    = cyc;
        e.due = cyc + lat;
        exp_q.push_back(e);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        op    = 2'($urandom);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 32'(exp_q.size()), 32'h0);
            exp_q.delete();
        end
    endtask

    task automatic run_one(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        int st;
        issue(o, x, y, st);
        wait_drain();
    endtask

    initial begin
        int st;
        int st2;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        compared   = 0;
        mismatched = 0;
        rstn  = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        check("reset_result", result, 32'h0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // DIV 100 / -7 with cycle-by-cycle busy profile.
        issue(OP_DIV, 32'd100, 32'hFFFF_FFF9, st);
        for (int k = 1; k <= 35; k++) begin
            check($sformatf("busy_c%0d", k), 32'(busy), (k <= 34) ? 32'h1 : 32'h0);
            @(posedge clk); #1;
        end
        wait_drain();

        run_one(OP_REM,  32'hFFFF_FF9C, 32'd7);
        run_one(OP_REM,  32'd100,       32'hFFFF_FFF9);
        run_one(OP_DIVU, 32'hFFFF_FFFF, 32'd2);
        run_one(OP_REMU, 32'hFFFF_FFFF, 32'd2);
        run_one(OP_DIV,  32'd5,         32'd0);
        run_one(OP_REM,  32'd5,         32'd0);
        run_one(OP_DIVU, 32'd0,         32'd0);
        run_one(OP_REMU, 32'd9,         32'd0);
        run_one(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF);
        run_one(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF);
        run_one(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF);
        run_one(OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF);
        run_one(OP_DIV,  32'h8000_0000, 32'd1);
        run_one(OP_DIV,  32'h8000_0000, 32'd3);

        // start in the middle of an operation is ignored.
        issue(OP_DIV, 32'd1000, 32'd7, st);
        wait_until(st + 10);
        op = OP_REMU; a = 32'd55; b = 32'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_drain();

        // start accepted in the DONE cycle.
        issue(OP_DIVU, 32'd12345, 32'd11, st);
        wait_until(st + 35);
        issue(OP_REM, 32'hFFFF_F000, 32'd9, st2);
        wait_drain();

        // Asynchronous reset mid-operation.
        issue(OP_DIV, 32'd1000, 32'd3, st);
        wait_until(st + 20);
        #2 rstn = 1'b0;
        #1;
        check("async_rst_busy", 32'(busy), 32'h0);
        check("async_rst_done", 32'(done), 32'h0);
        check("async_rst_result", result, 32'h0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        run_one(OP_DIV, 32'd7, 32'd2);

        // Randomized operands, biased toward special divisors, mixed with back-to-back.
        for (int i = 0; i < 60; i++) begin
            ro = 2'($urandom);
            ra = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'h0;
                1:       rb = 32'hFFFF_FFFF;
                2, 3:    rb = $urandom_range(1, 15);
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0 && exp_q.size() == 1) begin
                wait_until(exp_q[0].due);
                issue(ro, ra, rb, st);
            end else begin
                wait_drain();
                issue(ro, ra, rb, st);
            end
        end
        wait_drain();
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
